// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared raster timing constants for the video timing generator family, plus
// the helper functions used to size and sanity-check a raster geometry while
// the design elaborates.
//
// Contents:
//   VGA640_*   : 640x480 @ 60 Hz (25.175 MHz pixel clock), negative syncs
//   SVGA800_*  : 800x600 @ 60 Hz (40 MHz pixel clock), positive syncs
//   timing_total() : total length of one axis (sync + back + active + front)
//   timing_fits()  : true when a coordinate of the given width can hold
//                    every active position of the axis (0 .. active-1)
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // 640x480 @ 60 Hz
  localparam int   VGA640_H_ACTIVE = 640;
  localparam int   VGA640_H_FRONT  = 16;
  localparam int   VGA640_H_SYNC   = 96;
  localparam int   VGA640_H_BACK   = 48;
  localparam int   VGA640_V_ACTIVE = 480;
  localparam int   VGA640_V_FRONT  = 10;
  localparam int   VGA640_V_SYNC   = 2;
  localparam int   VGA640_V_BACK   = 33;
  localparam logic VGA640_HS_POL   = 1'b0;
  localparam logic VGA640_VS_POL   = 1'b0;

  // 800x600 @ 60 Hz
  localparam int   SVGA800_H_ACTIVE = 800;
  localparam int   SVGA800_H_FRONT  = 40;
  localparam int   SVGA800_H_SYNC   = 128;
  localparam int   SVGA800_H_BACK   = 88;
  localparam int   SVGA800_V_ACTIVE = 600;
  localparam int   SVGA800_V_FRONT  = 1;
  localparam int   SVGA800_V_SYNC   = 4;
  localparam int   SVGA800_V_BACK   = 23;
  localparam logic SVGA800_HS_POL   = 1'b1;
  localparam logic SVGA800_VS_POL   = 1'b1;

  // Length of one axis in pixels (horizontal) or lines (vertical).
  function automatic int timing_total(input int sync_w, input int back_w,
                                      input int active_w, input int front_w);
    return sync_w + back_w + active_w + front_w;
  endfunction

  // A coordinate of coord_w bits must reach active_w-1 without wrapping,
  // otherwise xPos/yPos alias and the start strobes fire more than once.
  function automatic bit timing_fits(input int active_w, input int coord_w);
    return (active_w >= 1) && (coord_w >= 1) && (coord_w <= 30) &&
           ((active_w - 1) < (1 << coord_w));
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// ---------------------------------------------------------------------------
// video_delay_line
//
// Enable-gated shift register used to align the raster outputs with a
// downstream pixel pipeline. Every stage advances only on clock edges where
// enable is high, so a divided pixel clock delays by DEPTH pixels, not by
// DEPTH raw clocks. All stages reset asynchronously to RST_VAL, which lets
// the caller give each bit of the bus its own idle level (e.g. an inactive
// sync polarity). DEPTH = 0 collapses to a plain wire.
//
// Parameters:
//   W       : bus width
//   DEPTH   : number of register stages (0 = combinational pass-through)
//   RST_VAL : per-bit value loaded into every stage on reset
//
// Ports:
//   vga_clk  in  1  pixel clock, posedge
//   reset_n  in  1  asynchronous active-low reset
//   enable   in  1  stage advance enable
//   din      in  W  bus into the first stage
//   dout     out W  bus out of the last stage
// ---------------------------------------------------------------------------
module video_delay_line #(
  parameter int           W       = 8,
  parameter int           DEPTH   = 0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         vga_clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    // Clock, reset and enable have no work to do without stages; folding
    // them into an unused sink keeps the port list identical for any DEPTH.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, vga_clk, reset_n, enable};
    assign dout = din;
  end else begin : g_pipe
    logic [W-1:0] taps [DEPTH];

    // Shift the whole bus one stage per enabled edge; reset drops every
    // stage back to the idle pattern at once so no stale pixel leaks out
    // after a mid-frame reset.
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          taps[i] <= RST_VAL;
        end
      end else if (enable) begin
        taps[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          taps[i] <= taps[i-1];
        end
      end
    end

    assign dout = taps[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Parametrised raster timing generator. Two counters walk the raster in the
// order sync, back porch, active, front porch on both axes. The counter state
// is decoded into syncs, blanking, active coordinates and start strobes; the
// decode is registered on the same enabled edge that advances the counters
// and then passes through an optional PIPE_DLY-stage delay line, so every
// output stays aligned with every other one.
//
// Ports:
//   vga_clk      in  1    pixel clock, posedge
//   reset_n      in  1    asynchronous active-low reset
//   enable       in  1    pixel clock enable; low freezes counters and pipe
//   HS           out 1    horizontal sync, active level HS_POL
//   VS           out 1    vertical sync, active level VS_POL
//   blank_n      out 1    high during active video
//   xPos         out X_W  active column, 0 while blanked
//   yPos         out Y_W  active row, 0 while blanked
//   line_start   out 1    one enabled cycle on the first pixel of each line
//   frame_start  out 1    one enabled cycle on pixel (0,0) of each frame
// ---------------------------------------------------------------------------
module video_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FRONT  = VGA640_H_FRONT,
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BACK   = VGA640_H_BACK,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FRONT  = VGA640_V_FRONT,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BACK   = VGA640_V_BACK,
  parameter logic HS_POL   = VGA640_HS_POL,
  parameter logic VS_POL   = VGA640_VS_POL,
  parameter int   PIPE_DLY = 0,
  parameter int   X_W      = 11,
  parameter int   Y_W      = 10
) (
  input  logic           vga_clk,
  input  logic           reset_n,
  input  logic           enable,
  output logic           HS,
  output logic           VS,
  output logic           blank_n,
  output logic [X_W-1:0] xPos,
  output logic [Y_W-1:0] yPos,
  output logic           line_start,
  output logic           frame_start
);

  localparam int H_TOTAL     = timing_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOTAL     = timing_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int V_ACT_START = V_SYNC + V_BACK;
  localparam int H_ACT_END   = H_TOTAL - H_FRONT;
  localparam int V_ACT_END   = V_TOTAL - V_FRONT;

  localparam int HC_W = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
  localparam int VC_W = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;

  localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);

  // Output bus layout, MSB first: HS, VS, blank_n, xPos, yPos, line_start,
  // frame_start. The idle pattern holds both syncs at their inactive level.
  localparam int BUS_W = 5 + X_W + Y_W;
  localparam logic [BUS_W-1:0] RST_BUS =
    {~HS_POL, ~VS_POL, 1'b0, {X_W{1'b0}}, {Y_W{1'b0}}, 1'b0, 1'b0};

  // Reject geometries that cannot be represented before anything is built.
  if (!timing_fits(H_ACTIVE, X_W)) begin : g_bad_x_w
    $error("video_timing_gen: X_W too narrow for H_ACTIVE");
  end
  if (!timing_fits(V_ACTIVE, Y_W)) begin : g_bad_y_w
    $error("video_timing_gen: Y_W too narrow for V_ACTIVE");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
    $error("video_timing_gen: PIPE_DLY must be 0..7");
  end
  if (H_SYNC < 1 || V_SYNC < 1 || H_BACK < 0 || V_BACK < 0 ||
      H_FRONT < 0 || V_FRONT < 0) begin : g_bad_porch
    $error("video_timing_gen: sync widths must be >= 1, porches >= 0");
  end

  logic [HC_W-1:0] h_cnt;
  logic [VC_W-1:0] v_cnt;

  // Raster position. The horizontal counter wraps every line and carries
  // into the vertical counter, which wraps at the end of the last line.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (enable) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + VC_W'(1);
        end
      end else begin
        h_cnt <= h_cnt + HC_W'(1);
      end
    end
  end

  logic [31:0]      h_wide;
  logic [31:0]      v_wide;
  logic             h_sync;
  logic             v_sync;
  logic             h_active;
  logic             v_active;
  logic             active;
  logic [HC_W-1:0]  h_off;
  logic [VC_W-1:0]  v_off;
  logic [X_W-1:0]   x_next;
  logic [Y_W-1:0]   y_next;
  logic             line_start_next;
  logic             frame_start_next;
  logic [BUS_W-1:0] decode_bus;

  // Decode the current counter state. Comparisons are done at 32 bits so a
  // zero front porch (active end equal to the total) cannot wrap the bound.
  // Coordinates are the counter-width difference truncated to X_W/Y_W.
  always_comb begin
    h_wide   = 32'(h_cnt);
    v_wide   = 32'(v_cnt);
    h_sync   = h_wide < 32'(H_SYNC);
    v_sync   = v_wide < 32'(V_SYNC);
    h_active = (h_wide >= 32'(H_ACT_START)) && (h_wide < 32'(H_ACT_END));
    v_active = (v_wide >= 32'(V_ACT_START)) && (v_wide < 32'(V_ACT_END));
    active   = h_active && v_active;

    h_off  = h_cnt - HC_W'(H_ACT_START);
    v_off  = v_cnt - VC_W'(V_ACT_START);
    x_next = '0;
    y_next = '0;
    if (active) begin
      x_next = X_W'(h_off);
      y_next = Y_W'(v_off);
    end

    line_start_next  = active && (x_next == '0);
    frame_start_next = line_start_next && (y_next == '0);

    decode_bus = {h_sync ? HS_POL : ~HS_POL,
                  v_sync ? VS_POL : ~VS_POL,
                  active, x_next, y_next,
                  line_start_next, frame_start_next};
  end

  logic [BUS_W-1:0] decode_q;

  // Register the decode on the same enabled edge that moves the counters,
  // so outputs always describe the position the counters just left.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      decode_q <= RST_BUS;
    end else if (enable) begin
      decode_q <= decode_bus;
    end
  end

  logic [BUS_W-1:0] out_bus;

  video_delay_line #(
    .W       (BUS_W),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (RST_BUS)
  ) u_delay (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .enable  (enable),
    .din     (decode_q),
    .dout    (out_bus)
  );

  assign {HS, VS, blank_n, xPos, yPos, line_start, frame_start} = out_bus;

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Four generators share one clock, reset and enable:
//   dut_a : small raster H 16/2/4/3, V 6/1/2/2 (25 x 11), negative syncs
//   dut_b : same raster as dut_a with PIPE_DLY = 3
//   dut_c : tiny raster H 8/1/2/1, V 4/1/1/1 (12 x 7), positive syncs
//   dut_d : default 640x480 geometry
// Inputs change right after a falling edge; outputs are sampled on falling
// edges, half a period away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable  = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 vga_clk = ~vga_clk;

  logic hs_a, vs_a, bl_a, ls_a, fs_a;
  logic [3:0] x_a;
  logic [2:0] y_a;
  logic hs_b, vs_b, bl_b, ls_b, fs_b;
  logic [3:0] x_b;
  logic [2:0] y_b;
  logic hs_c, vs_c, bl_c, ls_c, fs_c;
  logic [2:0] x_c;
  logic [1:0] y_c;
  logic hs_d, vs_d, bl_d, ls_d, fs_d;
  logic [10:0] x_d;
  logic [9:0]  y_d;

  logic [11:0] bus_a, bus_b;
  logic [9:0]  bus_c;
  logic [25:0] bus_d;
  assign bus_a = {hs_a, vs_a, bl_a, x_a, y_a, ls_a, fs_a};
  assign bus_b = {hs_b, vs_b, bl_b, x_b, y_b, ls_b, fs_b};
  assign bus_c = {hs_c, vs_c, bl_c, x_c, y_c, ls_c, fs_c};
  assign bus_d = {hs_d, vs_d, bl_d, x_d, y_d, ls_d, fs_d};

  video_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0), .X_W(4), .Y_W(3)
  ) dut_a (
    .vga_clk(vga_clk), .reset_n(reset_n), .enable(enable),
    .HS(hs_a), .VS(vs_a), .blank_n(bl_a), .xPos(x_a), .yPos(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3), .X_W(4), .Y_W(3)
  ) dut_b (
    .vga_clk(vga_clk), .reset_n(reset_n), .enable(enable),
    .HS(hs_b), .VS(vs_b), .blank_n(bl_b), .xPos(x_b), .yPos(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0), .X_W(3), .Y_W(2)
  ) dut_c (
    .vga_clk(vga_clk), .reset_n(reset_n), .enable(enable),
    .HS(hs_c), .VS(vs_c), .blank_n(bl_c), .xPos(x_c), .yPos(y_c),
    .line_start(ls_c), .frame_start(fs_c)
  );

  video_timing_gen dut_d (
    .vga_clk(vga_clk), .reset_n(reset_n), .enable(enable),
    .HS(hs_d), .VS(vs_d), .blank_n(bl_d), .xPos(x_d), .yPos(y_d),
    .line_start(ls_d), .frame_start(fs_d)
  );

  // Hold reset for three clocks with enable high, release on a falling edge.
  task automatic apply_reset();
    @(negedge vga_clk);
    reset_n = 1'b0;
    enable  = 1'b1;
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  // Reset values appear asynchronously, then the first enabled edge shows
  // counter state (0,0): syncs active, blanked.
  task automatic test_reset();
    @(negedge vga_clk);
    reset_n = 1'b0;
    #1;
    total++; if (bus_a !== 12'hC00) begin bad++; $display("[TB] FAIL reset_a got=%h want=%h", bus_a, 12'hC00); end
    total++; if (bus_b !== 12'hC00) begin bad++; $display("[TB] FAIL reset_b got=%h want=%h", bus_b, 12'hC00); end
    total++; if (bus_c !== 10'h000) begin bad++; $display("[TB] FAIL reset_c got=%h want=%h", bus_c, 10'h000); end
    total++; if (bus_d !== 26'h3000000) begin bad++; $display("[TB] FAIL reset_d got=%h want=%h", bus_d, 26'h3000000); end
    @(negedge vga_clk);
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge vga_clk);
    total++; if (bus_a !== 12'h000) begin bad++; $display("[TB] FAIL first_edge_a got=%h want=%h", bus_a, 12'h000); end
    total++; if (bus_b !== 12'hC00) begin bad++; $display("[TB] FAIL first_edge_b got=%h want=%h", bus_b, 12'hC00); end
    total++; if (bus_c !== 10'h300) begin bad++; $display("[TB] FAIL first_edge_c got=%h want=%h", bus_c, 10'h300); end
    total++; if (bus_d !== 26'h0) begin bad++; $display("[TB] FAIL first_edge_d got=%h want=%h", bus_d, 26'h0); end
  endtask

  // One full 25x11 frame plus the next frame's first active pixel.
  task automatic test_frame();
    int hs_low = 0, vs_low = 0, bl_cnt = 0, ls_cnt = 0, coord_bad = 0;
    int fs_cnt = 0, fs_idx0 = -1, fs_idx1 = -1, fall0 = -1, fall1 = -1;
    int last_x = -1, last_y = -1;
    logic fs_ok = 1'b0;
    logic prev_hs = 1'b1;
    apply_reset();
    for (int n = 1; n <= 383; n++) begin
      int idx;
      @(negedge vga_clk);
      idx = n - 1;
      if (idx < 275) begin
        hs_low += (hs_a == 1'b0) ? 1 : 0;
        vs_low += (vs_a == 1'b0) ? 1 : 0;
        bl_cnt += bl_a ? 1 : 0;
        ls_cnt += ls_a ? 1 : 0;
        if (bl_a) begin last_x = int'(x_a); last_y = int'(y_a); end
      end
      if (!bl_a && (x_a != 4'd0 || y_a != 3'd0)) coord_bad++;
      if (fs_a) begin
        fs_cnt++;
        if (fs_idx0 < 0) begin
          fs_idx0 = idx;
          fs_ok = bl_a && ls_a && (x_a == 4'd0) && (y_a == 3'd0);
        end else if (fs_idx1 < 0) begin
          fs_idx1 = idx;
        end
      end
      if (prev_hs && !hs_a) begin
        if (fall0 < 0) fall0 = idx; else if (fall1 < 0) fall1 = idx;
      end
      prev_hs = hs_a;
    end
    total++; if (hs_low != 44) begin bad++; $display("[TB] FAIL frame_hs_low got=%0d want=44", hs_low); end
    total++; if (vs_low != 50) begin bad++; $display("[TB] FAIL frame_vs_low got=%0d want=50", vs_low); end
    total++; if (bl_cnt != 96) begin bad++; $display("[TB] FAIL frame_blank_cnt got=%0d want=96", bl_cnt); end
    total++; if (ls_cnt != 6) begin bad++; $display("[TB] FAIL frame_line_starts got=%0d want=6", ls_cnt); end
    total++; if (fall1 - fall0 != 25) begin bad++; $display("[TB] FAIL frame_hs_period got=%0d want=25", fall1 - fall0); end
    total++; if (fs_idx0 != 107) begin bad++; $display("[TB] FAIL frame_fs_first got=%0d want=107", fs_idx0); end
    total++; if (fs_idx1 != 382 || fs_cnt != 2) begin bad++; $display("[TB] FAIL frame_fs_second got=%0d/%0d want=382/2", fs_idx1, fs_cnt); end
    total++; if (!fs_ok) begin bad++; $display("[TB] FAIL frame_fs_origin got=0 want=1"); end
    total++; if (last_x != 15 || last_y != 5) begin bad++; $display("[TB] FAIL frame_last_pixel got=%0d,%0d want=15,5", last_x, last_y); end
    total++; if (coord_bad != 0) begin bad++; $display("[TB] FAIL frame_coord_blanked got=%0d want=0", coord_bad); end
  endtask

  // dut_b must reproduce dut_a exactly, three enabled edges later.
  task automatic test_pipe_delay();
    logic [11:0] hist [0:127];
    int mis = 0;
    logic [11:0] early_b = 12'h000;
    apply_reset();
    for (int n = 1; n <= 120; n++) begin
      int idx;
      logic [11:0] want;
      @(negedge vga_clk);
      idx = n - 1;
      hist[idx] = bus_a;
      want = (idx >= 3) ? hist[idx-3] : 12'hC00;
      if (bus_b !== want) mis++;
      if (idx == 2) early_b = bus_b;
    end
    total++; if (early_b !== 12'hC00) begin bad++; $display("[TB] FAIL pipe_still_reset got=%h want=%h", early_b, 12'hC00); end
    total++; if (mis != 0) begin bad++; $display("[TB] FAIL pipe_alignment got=%0d want=0", mis); end
  endtask

  // Enable high every other clock: periods double, nothing moves on idle edges.
  task automatic test_enable_toggle();
    logic [11:0] prev_a = 12'hC00;
    logic [11:0] prev_b = 12'hC00;
    logic prev_hs = 1'b1;
    int hold_bad = 0, ls_cnt = 0, fs_cnt = 0, fs_first = -1, fall0 = -1, fall1 = -1;
    apply_reset();
    for (int n = 0; n < 550; n++) begin
      logic en_now;
      en_now = (n % 2 == 0);
      enable = en_now;
      @(negedge vga_clk);
      if (!en_now && (bus_a !== prev_a || bus_b !== prev_b)) hold_bad++;
      ls_cnt += ls_a ? 1 : 0;
      if (fs_a) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = n;
      end
      if (prev_hs && !hs_a) begin
        if (fall0 < 0) fall0 = n; else if (fall1 < 0) fall1 = n;
      end
      prev_hs = hs_a;
      prev_a = bus_a;
      prev_b = bus_b;
    end
    enable = 1'b1;
    total++; if (hold_bad != 0) begin bad++; $display("[TB] FAIL en_hold got=%0d want=0", hold_bad); end
    total++; if (fall1 - fall0 != 50) begin bad++; $display("[TB] FAIL en_hs_period got=%0d want=50", fall1 - fall0); end
    total++; if (ls_cnt != 12) begin bad++; $display("[TB] FAIL en_line_start_clks got=%0d want=12", ls_cnt); end
    total++; if (fs_cnt != 2 || fs_first != 214) begin bad++; $display("[TB] FAIL en_frame_start got=%0d@%0d want=2@214", fs_cnt, fs_first); end
  endtask

  // Positive-polarity tiny raster, one 12x7 frame.
  task automatic test_tiny_raster();
    int hs_high = 0, vs_high = 0, bl_cnt = 0, max_x = 0, max_y = 0, fs_idx = -1;
    logic hs_at2 = 1'b1;
    apply_reset();
    for (int n = 1; n <= 84; n++) begin
      int idx;
      @(negedge vga_clk);
      idx = n - 1;
      hs_high += hs_c ? 1 : 0;
      vs_high += vs_c ? 1 : 0;
      bl_cnt  += bl_c ? 1 : 0;
      if (int'(x_c) > max_x) max_x = int'(x_c);
      if (int'(y_c) > max_y) max_y = int'(y_c);
      if (fs_c && fs_idx < 0) fs_idx = idx;
      if (idx == 2) hs_at2 = hs_c;
    end
    total++; if (hs_high != 14) begin bad++; $display("[TB] FAIL tiny_hs_high got=%0d want=14", hs_high); end
    total++; if (vs_high != 12) begin bad++; $display("[TB] FAIL tiny_vs_high got=%0d want=12", vs_high); end
    total++; if (hs_at2 !== 1'b0) begin bad++; $display("[TB] FAIL tiny_hs_end got=%b want=0", hs_at2); end
    total++; if (bl_cnt != 32) begin bad++; $display("[TB] FAIL tiny_blank_cnt got=%0d want=32", bl_cnt); end
    total++; if (max_x != 7 || max_y != 3) begin bad++; $display("[TB] FAIL tiny_max_xy got=%0d,%0d want=7,3", max_x, max_y); end
    total++; if (fs_idx != 27) begin bad++; $display("[TB] FAIL tiny_fs_idx got=%0d want=27", fs_idx); end
  endtask

  // Reset at (h=10,v=5): immediate reset values, restart from (0,0).
  task automatic test_mid_reset();
    int fs_n = -1;
    apply_reset();
    repeat (136) @(negedge vga_clk);
    total++; if (bus_a !== 12'hE64) begin bad++; $display("[TB] FAIL mid_pos got=%h want=%h", bus_a, 12'hE64); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (bus_a !== 12'hC00 || bus_b !== 12'hC00) begin bad++; $display("[TB] FAIL mid_async got=%h/%h want=%h", bus_a, bus_b, 12'hC00); end
    repeat (5) @(negedge vga_clk);
    total++; if (bus_a !== 12'hC00) begin bad++; $display("[TB] FAIL mid_held got=%h want=%h", bus_a, 12'hC00); end
    reset_n = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge vga_clk);
      if (n == 1) begin
        total++; if (bus_a !== 12'h000) begin bad++; $display("[TB] FAIL mid_restart got=%h want=%h", bus_a, 12'h000); end
      end
      if (fs_a) begin fs_n = n; break; end
    end
    total++; if (fs_n != 108) begin bad++; $display("[TB] FAIL mid_fs_delay got=%0d want=108", fs_n); end
  endtask

  // Default 640x480 geometry up to the first frame_start.
  task automatic test_default_raster();
    int hs_low = 0, vs_low = 0, fall0 = -1, fall1 = -1, fs_n = -1;
    logic vs_at = 1'b0;
    logic fs_ok = 1'b0;
    logic prev_hs = 1'b1;
    apply_reset();
    for (int n = 1; n <= 28200; n++) begin
      int idx;
      @(negedge vga_clk);
      idx = n - 1;
      if (idx < 800)  hs_low += (hs_d == 1'b0) ? 1 : 0;
      if (idx < 1600) vs_low += (vs_d == 1'b0) ? 1 : 0;
      if (idx == 1600) vs_at = vs_d;
      if (prev_hs && !hs_d) begin
        if (fall0 < 0) fall0 = idx; else if (fall1 < 0) fall1 = idx;
      end
      prev_hs = hs_d;
      if (fs_d) begin
        fs_n = n;
        fs_ok = bl_d && ls_d && (x_d == 11'd0) && (y_d == 10'd0);
        break;
      end
    end
    total++; if (hs_low != 96) begin bad++; $display("[TB] FAIL vga_hs_low got=%0d want=96", hs_low); end
    total++; if (fall1 - fall0 != 800) begin bad++; $display("[TB] FAIL vga_hs_period got=%0d want=800", fall1 - fall0); end
    total++; if (vs_low != 1600 || vs_at !== 1'b1) begin bad++; $display("[TB] FAIL vga_vs_low got=%0d/%b want=1600/1", vs_low, vs_at); end
    total++; if (fs_n != 28145) begin bad++; $display("[TB] FAIL vga_fs_delay got=%0d want=28145", fs_n); end
    total++; if (!fs_ok) begin bad++; $display("[TB] FAIL vga_fs_origin got=0 want=1"); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_pipe_delay();
    test_enable_toggle();
    test_tiny_raster();
    test_mid_reset();
    test_default_raster();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
